key_expander: RTL and testbench
===============================

# key_expander

Sequential AES-128 key expansion controller that sits directly upstream of the round datapath. It accepts one 128-bit cipher key over a valid/ready handshake. It then iterates the combinational `key_schedule` stage (NUM_WORDS = 4) once per round to produce round keys 0..NUM_ROUNDS. Round keys are streamed out one per beat under downstream back-pressure, so the cipher core consumes them as it advances.

## Interface

Parameters:
- `NUM_ROUNDS`, default 10: index of the last round key emitted. Legal range is 1..10, bounded by the `rc` table; out-of-range values are an elaboration error.

Ports (clock and reset first). One clock; reset is synchronous and active-high.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `key_valid`  input  1  `key_in` holds a new cipher key.
- `key_ready`  output  1  the block accepts a key this cycle.
- `key_in`  input  [31:0] x4 (unpacked `[4]`)  cipher key words w0..w3.
- `rk_valid`  output  1  `rk_out` holds a round key.
- `rk_ready`  input  1  downstream consumes `rk_out` this cycle.
- `rk_out`  output  [31:0] x4 (unpacked `[4]`)  current round key words.
- `rk_index`  output  4  round number of `rk_out` (0..NUM_ROUNDS).
- `rk_last`  output  1  high with `rk_valid` when `rk_index == NUM_ROUNDS`.
- `busy`  output  1  a key is being expanded (state EMIT).

Byte order: byte k of a word occupies bits [8k+7:8k]. Key byte 4i+k maps to word i, byte k, matching `key_schedule`/`g`.

## Operation

- Registers:
  - `cur[4]` (round key words)
  - `round` (4 bits)
  - `state` ∈ {IDLE, EMIT}
- One `key_schedule` instance:
  - `rc = round`, `key_current = cur`; its `key_next` feeds `cur`.
  - Producing key r+1 therefore uses rcon(r): rc=0 gives 0x01, up to rc=9 giving 0x36.
- IDLE:
  - `key_ready = 1`, `rk_valid = 0`, `busy = 0`.
  - On `key_valid && key_ready`: `cur <= key_in`, `round <= 0`, go to EMIT.
- EMIT:
  - `key_ready = 0`, `rk_valid = 1`, `busy = 1`.
  - `rk_out = cur`, `rk_index = round`.
  - On `rk_ready` with `round < NUM_ROUNDS`: `cur <= key_next`, `round <= round + 1`.
  - On `rk_ready` with `round == NUM_ROUNDS`: go to IDLE, `cur <= 0` (key material zeroized), `round <= 0`.
  - Without `rk_ready`: all state holds.
- Outputs `rk_out`, `rk_index`, `rk_valid`, `rk_last`, `busy` and `key_ready` are decoded only from registers; no combinational path from `rk_ready` or `key_valid` to any output.
- `key_in` and `key_valid` are ignored outside IDLE. A key cannot be accepted on the same cycle as the final round-key handshake.
- Reset, at any time including mid-expansion:
  - State after the edge: `state = IDLE`, `cur = 0`, `round = 0`.
  - Outputs after the edge: `rk_valid = 0`, `rk_last = 0`, `busy = 0`, `rk_index = 0`, `rk_out = 0`, `key_ready = 1`.
  - The partial key stream is abandoned with no further beats.
  - `key_valid` is ignored while `rst` is high.

## Timing

- Key handshake at edge T gives `rk_valid = 1`, `rk_index = 0` in cycle T+1.
- With `rk_ready` held high: one key per cycle. Index NUM_ROUNDS is presented at T+1+NUM_ROUNDS, and `key_ready` returns at T+2+NUM_ROUNDS.
- Minimum key-to-key period is NUM_ROUNDS+2 cycles.
- Under back-pressure, `rk_out`, `rk_index` and `rk_last` are stable while `rk_valid && !rk_ready`. `rk_valid` never drops without a handshake except via reset.
- Combinational critical path is one `key_schedule` evaluation (4 S-boxes plus an XOR chain) into `cur`.

## Test plan

- FIPS-197 key `2b7e1516 28aed2a6 abf71588 09cf4f3c`, i.e. w0 = 32'h16157e2b, `rk_ready` tied high:
  - index 0 equals the key;
  - index 1 equals bytes `a0fafe17 88542cb1 23a33939 2a6c7605`;
  - index 10 equals `d014f9a8 c9ee2589 e13f0cc8 b6630ca6` with `rk_last = 1`;
  - exactly 11 beats; `key_ready` high 12 cycles after acceptance.
- All-zero key: index 1 gives every word = 32'h63636362; index 10 gives bytes `b4ef5bcb 3e92e211 23e951cf 6f8f188e`.
- Random `rk_ready` stalls (about 50%): the beat sequence matches the unstalled run, and outputs are held stable across every stall cycle.
- `key_valid` pulsed with a different key during EMIT: ignored, the stream continues unchanged, `key_ready = 0` throughout.
- `rst` asserted after beat 4:
  - next cycle `rk_valid = 0`, `rk_out = 0`, `key_ready = 1`;
  - a fresh key afterwards streams correctly from index 0.
- `NUM_ROUNDS = 1`: exactly two beats (indices 0, 1), `rk_last` on the second, and `cur` reads zero on return to IDLE.

Source files
------------

// File: rtl/key_expander.sv
// AES-128 key expansion controller: accepts one cipher key, then streams round
// keys 0..NUM_ROUNDS one per handshake by iterating a single key_schedule stage.

module key_schedule (
    input  logic [3:0]  rc,
    input  logic [31:0] key_current [4],
    output logic [31:0] key_next    [4]
);

    // FIPS-197 S-box, entry 0x00 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[8 * (255 - int'(b)) +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd0:    v = 8'h01;
            4'd1:    v = 8'h02;
            4'd2:    v = 8'h04;
            4'd3:    v = 8'h08;
            4'd4:    v = 8'h10;
            4'd5:    v = 8'h20;
            4'd6:    v = 8'h40;
            4'd7:    v = 8'h80;
            4'd8:    v = 8'h1b;
            4'd9:    v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // Byte 0 sits in the low bits, so RotWord moves byte 1 down into byte 0.
    function automatic logic [31:0] g(input logic [31:0] w, input logic [3:0] r);
        return {sbox(w[7:0]), sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8])}
               ^ {24'h0, rcon(r)};
    endfunction

    logic [31:0] n0, n1, n2, n3;

    // NOTE: combinational logic uses blocking assignments so each word sees the
    // freshly computed previous word; every output is assigned on every pass.
    always_comb begin
        n0 = key_current[0] ^ g(key_current[3], rc);
        n1 = key_current[1] ^ n0;
        n2 = key_current[2] ^ n1;
        n3 = key_current[3] ^ n2;
        key_next[0] = n0;
        key_next[1] = n1;
        key_next[2] = n2;
        key_next[3] = n3;
    end

endmodule

module key_expander #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    output logic        key_ready,
    input  logic [31:0] key_in [4],
    output logic        rk_valid,
    input  logic        rk_ready,
    output logic [31:0] rk_out [4],
    output logic [3:0]  rk_index,
    output logic        rk_last,
    output logic        busy
);

    generate
        if (NUM_ROUNDS < 1 || NUM_ROUNDS > 10) begin : g_bad_num_rounds
            $error("key_expander: NUM_ROUNDS must be in 1..10");
        end
    endgenerate

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic {
        IDLE,
        EMIT
    } state_t;

    state_t      state;
    logic [31:0] cur [4];
    logic [3:0]  round;
    logic [31:0] key_next [4];

    key_schedule u_key_schedule (
        .rc          (round),
        .key_current (cur),
        .key_next    (key_next)
    );

    // NOTE: sequential state uses non-blocking assignments only. The key
    // registers are reset (and cleared after the last beat) on purpose so no
    // key material lingers once a stream ends or is abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '{default: '0};
            round     <= '0;
            key_ready <= 1'b1;
            rk_valid  <= 1'b0;
            rk_last   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        state     <= EMIT;
                        cur       <= key_in;
                        round     <= '0;
                        key_ready <= 1'b0;
                        rk_valid  <= 1'b1;
                        rk_last   <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                EMIT: begin
                    if (rk_ready) begin
                        if (round == LAST_ROUND) begin
                            state     <= IDLE;
                            cur       <= '{default: '0};
                            round     <= '0;
                            key_ready <= 1'b1;
                            rk_valid  <= 1'b0;
                            rk_last   <= 1'b0;
                            busy      <= 1'b0;
                        end else begin
                            cur     <= key_next;
                            round   <= round + 4'd1;
                            rk_last <= (round + 4'd1 == LAST_ROUND);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rk_out   = cur;
    assign rk_index = round;

endmodule

// File: tb/tb_key_expander.sv
// Self-checking bench for key_expander: known-answer table, model-checked
// random keys with random back-pressure, and multi-cycle corner sequences.

module tb_key_expander;

    localparam int NR = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, key_valid, key_ready, rk_valid, rk_ready, rk_last, busy;
    logic [31:0] key_in [4];
    logic [31:0] rk_out [4];
    logic [3:0]  rk_index;

    logic        s_key_valid, s_key_ready, s_rk_valid, s_rk_ready, s_rk_last, s_busy;
    logic [31:0] s_key_in [4];
    logic [31:0] s_rk_out [4];
    logic [3:0]  s_rk_index;

    key_expander #(.NUM_ROUNDS(NR)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_ready(key_ready),
        .key_in(key_in), .rk_valid(rk_valid), .rk_ready(rk_ready),
        .rk_out(rk_out), .rk_index(rk_index), .rk_last(rk_last), .busy(busy)
    );

    key_expander #(.NUM_ROUNDS(1)) dut1 (
        .clk(clk), .rst(rst), .key_valid(s_key_valid), .key_ready(s_key_ready),
        .key_in(s_key_in), .rk_valid(s_rk_valid), .rk_ready(s_rk_ready),
        .rk_out(s_rk_out), .rk_index(s_rk_index), .rk_last(s_rk_last), .busy(s_busy)
    );

    logic [127:0] rk_flat, s_rk_flat;
    assign rk_flat   = {rk_out[3], rk_out[2], rk_out[1], rk_out[0]};
    assign s_rk_flat = {s_rk_out[3], s_rk_out[2], s_rk_out[1], s_rk_out[0]};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: FIPS-197 expansion on a flat byte array, S-box derived
    // from GF(2^8) inversion plus the affine map.
    logic [7:0]   sbox_m [256];
    logic [7:0]   rcon_m [10];
    logic [127:0] exp_rk [11];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic init_tables();
        logic [7:0] inv, rc;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256 && x != 0; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) begin
                    inv = 8'(y);
                    break;
                end
            sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                        ^ rotl8(inv, 4) ^ 8'h63;
        end
        rc = 8'h01;
        for (int n = 0; n < 10; n++) begin
            rcon_m[n] = rc;
            rc = gmul(rc, 8'h02);
        end
    endtask

    task automatic model_expand(input logic [127:0] k);
        logic [7:0] b [176];
        logic [7:0] t [4];
        logic [7:0] u [4];
        for (int j = 0; j < 16; j++) b[j] = k[8*j +: 8];
        for (int i = 4; i < 44; i++) begin
            for (int kk = 0; kk < 4; kk++) t[kk] = b[4*(i-1) + kk];
            if (i % 4 == 0) begin
                for (int kk = 0; kk < 4; kk++) u[kk] = sbox_m[t[(kk+1) % 4]];
                u[0] = u[0] ^ rcon_m[i/4 - 1];
                t = u;
            end
            for (int kk = 0; kk < 4; kk++) b[4*i + kk] = b[4*(i-4) + kk] ^ t[kk];
        end
        for (int r = 0; r <= NR; r++)
            for (int j = 0; j < 16; j++) exp_rk[r][8*j +: 8] = b[16*r + j];
    endtask

    task automatic set_key(input logic [127:0] k);
        for (int i = 0; i < 4; i++) key_in[i] = k[32*i +: 32];
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Captured beats of the most recent stream.
    logic [127:0] got_rk   [16];
    logic [3:0]   got_idx  [16];
    logic         got_last [16];
    int           nbeats;

    task automatic run_stream(input logic [127:0] k, input int stall_pct, input bit inject);
        logic         rr;
        logic [132:0] hold;
        int           cyc;
        @(negedge clk);
        check("key_ready_before_accept", key_ready, 1'b1);
        set_key(k);
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        nbeats = 0;
        cyc = 0;
        hold = '0;
        while (rk_valid && cyc < 400) begin
            if (inject) begin
                set_key(rand128());
                key_valid = 1'b1;
                check("key_ready_low_in_emit", key_ready, 1'b0);
            end
            rr = ($urandom_range(0, 99) >= stall_pct);
            rk_ready = rr;
            if (rr) begin
                if (nbeats < 16) begin
                    got_rk[nbeats]   = rk_flat;
                    got_idx[nbeats]  = rk_index;
                    got_last[nbeats] = rk_last;
                end
                nbeats++;
            end else begin
                hold = {rk_flat, rk_index, rk_last};
            end
            @(negedge clk);
            if (!rr) check("stall_hold", {rk_valid, rk_flat, rk_index, rk_last}, {1'b1, hold});
            cyc++;
        end
        key_valid = 1'b0;
        rk_ready  = 1'b0;
        if (cyc >= 400) check("stream_timeout", 1'b1, 1'b0);
        check("idle_after_stream", {key_ready, busy, rk_flat}, {1'b1, 1'b0, 128'h0});
    endtask

    task automatic compare_stream(input string name);
        check({name, "_beats"}, nbeats, NR + 1);
        for (int r = 0; r <= NR && r < nbeats; r++)
            check({name, "_beat"}, {got_idx[r], got_last[r], got_rk[r]},
                  {4'(r), (r == NR), exp_rk[r]});
    endtask

    typedef struct {
        string        name;
        logic [127:0] key;
        int           idx;
        logic [127:0] exp;
        logic         last;
    } vec_t;

    vec_t vecs [5];

    localparam logic [127:0] FIPS_KEY = {32'h3c4fcf09, 32'h8815f7ab, 32'ha6d2ae28, 32'h16157e2b};

    initial begin
        logic [127:0] k;
        int           n;

        vecs[0] = '{"fips_r0",  FIPS_KEY, 0, FIPS_KEY, 1'b0};
        vecs[1] = '{"fips_r1",  FIPS_KEY, 1,
                    {32'h05766c2a, 32'h3939a323, 32'hb12c5488, 32'h17fefaa0}, 1'b0};
        vecs[2] = '{"fips_r10", FIPS_KEY, 10,
                    {32'ha60c63b6, 32'hc80c3fe1, 32'h8925eec9, 32'ha8f914d0}, 1'b1};
        vecs[3] = '{"zero_r1",  128'h0, 1, {4{32'h63636362}}, 1'b0};
        vecs[4] = '{"zero_r10", 128'h0, 10,
                    {32'h8e188f6f, 32'hcf51e923, 32'h11e2923e, 32'hcb5befb4}, 1'b1};

        init_tables();

        rst = 1'b1; key_valid = 1'b0; rk_ready = 1'b0; set_key('0);
        s_key_valid = 1'b0; s_rk_ready = 1'b0;
        for (int i = 0; i < 4; i++) s_key_in[i] = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {key_ready, rk_valid, rk_last, busy, rk_index, rk_flat},
              {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 128'h0});
        rst = 1'b0;

        // Known-answer table.
        foreach (vecs[v]) begin
            run_stream(vecs[v].key, 0, 1'b0);
            check({vecs[v].name, "_beats"}, nbeats, NR + 1);
            check(vecs[v].name, {got_idx[vecs[v].idx], got_last[vecs[v].idx], got_rk[vecs[v].idx]},
                  {4'(vecs[v].idx), vecs[v].last, vecs[v].exp});
        end

        // Key handshake to key_ready return, rk_ready held high.
        @(negedge clk);
        set_key(FIPS_KEY);
        key_valid = 1'b1;
        rk_ready  = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        check("first_beat_latency", {rk_valid, rk_index}, {1'b1, 4'd0});
        n = 1;
        while (!key_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("key_ready_return_cycles", n, 12);
        rk_ready = 1'b0;

        // Random keys with ~50% stalls; one run also pulses key_valid during EMIT.
        for (int t = 0; t < 6; t++) begin
            k = rand128();
            model_expand(k);
            run_stream(k, 50, t == 3);
            compare_stream(t == 3 ? "rand_inject" : "rand_stall");
        end

        // Reset in the middle of a stream.
        k = rand128();
        @(negedge clk);
        set_key(k);
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
        rk_ready  = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_reset_index", {rk_valid, rk_index}, {1'b1, 4'd4});
        rst = 1'b1;
        rk_ready = 1'b0;
        set_key(rand128());
        key_valid = 1'b1;
        @(negedge clk);
        check("mid_reset_outputs", {key_ready, rk_valid, rk_last, busy, rk_index, rk_flat},
              {1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 128'h0});
        rst = 1'b0;
        key_valid = 1'b0;
        @(negedge clk);
        check("reset_ignores_key_valid", {rk_valid, key_ready}, {1'b0, 1'b1});
        k = rand128();
        model_expand(k);
        run_stream(k, 0, 1'b0);
        compare_stream("after_reset");

        // NUM_ROUNDS = 1 instance.
        k = rand128();
        model_expand(k);
        @(negedge clk);
        check("nr1_ready", s_key_ready, 1'b1);
        for (int i = 0; i < 4; i++) s_key_in[i] = k[32*i +: 32];
        s_key_valid = 1'b1;
        @(negedge clk);
        s_key_valid = 1'b0;
        s_rk_ready  = 1'b1;
        check("nr1_beat0", {s_rk_valid, s_rk_index, s_rk_last, s_rk_flat}, {1'b1, 4'd0, 1'b0, k});
        @(negedge clk);
        check("nr1_beat1", {s_rk_valid, s_rk_index, s_rk_last, s_rk_flat}, {1'b1, 4'd1, 1'b1, exp_rk[1]});
        @(negedge clk);
        s_rk_ready = 1'b0;
        check("nr1_idle_zeroized", {s_rk_valid, s_key_ready, s_busy, s_rk_flat},
              {1'b0, 1'b1, 1'b0, 128'h0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
